// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with a manual select mode and an auto-scan mode.
// Auto-scan visits the enabled channels round-robin, dwelling DWELL cycles on each.
module mux_scan #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 4,
    parameter int DWELL  = 3,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH-1:0]          en_mask,
    input  logic [N_CH*DATA_W-1:0]   din,
    output logic [DATA_W-1:0]        dout,
    output logic [SEL_W-1:0]         dout_ch,
    output logic                     dout_valid,
    output logic                     scan_wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {MANUAL, SCAN, EMPTY} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   cur_ch, cur_ch_nxt;
    logic [CNT_W-1:0]   dwell_cnt, dwell_cnt_nxt;
    logic [DATA_W-1:0]  dout_nxt;
    logic [SEL_W-1:0]   dout_ch_nxt;
    logic               dout_valid_nxt;
    logic               scan_wrap_nxt;
    logic [SEL_W-1:0]   next_ch;

    function automatic logic mask_bit(input logic [N_CH-1:0] m, input logic [SEL_W-1:0] c);
        logic [N_CH-1:0] sh;
        sh = m >> c;
        return sh[0];
    endfunction

    function automatic logic [DATA_W-1:0] chan_data(input logic [SEL_W-1:0] c);
        logic [N_CH*DATA_W-1:0] sh;
        sh = din >> (int'(c) * DATA_W);
        return sh[DATA_W-1:0];
    endfunction

    function automatic logic [SEL_W-1:0] lowest_en(input logic [N_CH-1:0] m);
        logic [N_CH-1:0] sh;
        lowest_en = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            sh = m >> i;
            if (sh[0]) lowest_en = SEL_W'(i);
        end
    endfunction

    // Searches downward in offset so the nearest enabled channel above c wins;
    // offset N_CH lands back on c itself, covering the single-channel case.
    function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] c,
                                                 input logic [N_CH-1:0] m);
        logic [N_CH-1:0] sh;
        int idx;
        next_en = c;
        for (int i = N_CH; i >= 1; i--) begin
            idx = (int'(c) + i) % N_CH;
            sh  = m >> idx;
            if (sh[0]) next_en = SEL_W'(idx);
        end
    endfunction

    assign next_ch = next_en(cur_ch, en_mask);

    always_comb begin
        state_nxt      = state;
        cur_ch_nxt     = cur_ch;
        dwell_cnt_nxt  = dwell_cnt;
        dout_nxt       = dout;
        dout_ch_nxt    = dout_ch;
        dout_valid_nxt = 1'b0;
        scan_wrap_nxt  = 1'b0;

        if (!mode) begin
            state_nxt = MANUAL;
            if ((int'(sel) < N_CH) && mask_bit(en_mask, sel)) begin
                dout_nxt       = chan_data(sel);
                dout_ch_nxt    = sel;
                dout_valid_nxt = 1'b1;
            end
        end else begin
            case (state)
                MANUAL, EMPTY: begin
                    // Entry edge only arms the scan; the first sample lands on the next edge.
                    if (en_mask != '0) begin
                        state_nxt     = SCAN;
                        cur_ch_nxt    = lowest_en(en_mask);
                        dwell_cnt_nxt = '0;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
                SCAN: begin
                    if (en_mask == '0) begin
                        state_nxt = EMPTY;
                    end else if (!mask_bit(en_mask, cur_ch)) begin
                        cur_ch_nxt    = next_ch;
                        dwell_cnt_nxt = '0;
                        scan_wrap_nxt = (next_ch <= cur_ch);
                    end else begin
                        dout_nxt       = chan_data(cur_ch);
                        dout_ch_nxt    = cur_ch;
                        dout_valid_nxt = 1'b1;
                        if (dwell_cnt == CNT_W'(DWELL - 1)) begin
                            dwell_cnt_nxt = '0;
                            cur_ch_nxt    = next_ch;
                            scan_wrap_nxt = (next_ch <= cur_ch);
                        end else begin
                            dwell_cnt_nxt = dwell_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state_nxt = MANUAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MANUAL;
            cur_ch     <= '0;
            dwell_cnt  <= '0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            scan_wrap  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_ch     <= cur_ch_nxt;
            dwell_cnt  <= dwell_cnt_nxt;
            dout       <= dout_nxt;
            dout_ch    <= dout_ch_nxt;
            dout_valid <= dout_valid_nxt;
            scan_wrap  <= scan_wrap_nxt;
        end
    end

endmodule
